// File: rtl/nebula_packet_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : nebula_packet_assembler
//  Purpose  : Accepts one packet request (header + payload) and slices it into
//             up to FLITS_PER_PACKET NoC flits of 208 payload bits each.
//             Requests that need more flits than allowed are dropped
//             with a one-cycle protocol error pulse.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                     clock, asynchronous active-high reset
//    pkt_valid / pkt_ready        packet request handshake (ready only in IDLE)
//    src_x, src_y, dest_x, dest_y packet coordinates
//    vc_id, qos                   virtual channel and priority
//    payload_data                 payload, byte 0 at bits [7:0]
//    payload_size                 payload length in bytes
//    flit_valid / flit_ready      flit handshake
//    flit_out                     assembled flit (noc_flit_t)
//    error_detected               one-cycle error pulse
//    error_code                   last error seen
//  Optional feature (macro NEBULA_ASM_STATS_EN)
//    stats_pkt_count  [31:0]      packets fully sent   (saturating)
//    stats_flit_count [31:0]      flits transferred    (saturating)
//    stats_drop_count [15:0]      DROP entries         (saturating)
// ============================================================================

package nebula_pkg;
    localparam int COORD_WIDTH        = 4;
    localparam int VC_ID_WIDTH        = 2;
    localparam int QOS_WIDTH          = 4;
    localparam int SEQ_WIDTH          = 8;
    localparam int PKT_ID_WIDTH       = 8;
    localparam int FLIT_PAYLOAD_WIDTH = 208;

    typedef enum logic [1:0] {
        FLIT_HEAD   = 2'd0,
        FLIT_BODY   = 2'd1,
        FLIT_TAIL   = 2'd2,
        FLIT_SINGLE = 2'd3
    } flit_type_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_PROTOCOL  = 2'd1,
        ERR_RESERVED2 = 2'd2,
        ERR_RESERVED3 = 2'd3
    } error_code_e;

    typedef struct packed {
        flit_type_e                     flit_type;
        logic [COORD_WIDTH-1:0]         src_x;
        logic [COORD_WIDTH-1:0]         src_y;
        logic [COORD_WIDTH-1:0]         dest_x;
        logic [COORD_WIDTH-1:0]         dest_y;
        logic [VC_ID_WIDTH-1:0]         vc_id;
        logic [QOS_WIDTH-1:0]           qos;
        logic [PKT_ID_WIDTH-1:0]        packet_id;
        logic [SEQ_WIDTH-1:0]           seq_num;
        logic [FLIT_PAYLOAD_WIDTH-1:0]  payload;
    } noc_flit_t;
endpackage

module nebula_packet_assembler
    import nebula_pkg::*;
#(
    parameter int MAX_PAYLOAD_SIZE = 1024,
    parameter int FLITS_PER_PACKET = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 pkt_valid,
    output logic                                 pkt_ready,
    input  logic [COORD_WIDTH-1:0]               src_x,
    input  logic [COORD_WIDTH-1:0]               src_y,
    input  logic [COORD_WIDTH-1:0]               dest_x,
    input  logic [COORD_WIDTH-1:0]               dest_y,
    input  logic [VC_ID_WIDTH-1:0]               vc_id,
    input  logic [QOS_WIDTH-1:0]                 qos,
    input  logic [MAX_PAYLOAD_SIZE*8-1:0]        payload_data,
    input  logic [$clog2(MAX_PAYLOAD_SIZE)-1:0]  payload_size,
    output logic                                 flit_valid,
    output noc_flit_t                            flit_out,
    input  logic                                 flit_ready,
    output logic                                 error_detected,
    output error_code_e                          error_code
`ifdef NEBULA_ASM_STATS_EN
    ,
    output logic [31:0]                          stats_pkt_count,
    output logic [31:0]                          stats_flit_count,
    output logic [15:0]                          stats_drop_count
`endif
);

    localparam int SIZE_W    = $clog2(MAX_PAYLOAD_SIZE);
    localparam int CAP_W     = FLITS_PER_PACKET * FLIT_PAYLOAD_WIDTH;
    localparam int CAP_BYTES = CAP_W / 8;
    localparam int N_W       = $clog2(FLITS_PER_PACKET + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DROP = 2'd2
    } state_e;

    typedef struct packed {
        logic [COORD_WIDTH-1:0] src_x;
        logic [COORD_WIDTH-1:0] src_y;
        logic [COORD_WIDTH-1:0] dest_x;
        logic [COORD_WIDTH-1:0] dest_y;
        logic [VC_ID_WIDTH-1:0] vc_id;
        logic [QOS_WIDTH-1:0]   qos;
    } hdr_t;

    state_e                   state_q,  state_d;
    logic [CAP_W-1:0]         payload_q, payload_d;
    logic [N_W-1:0]           nflits_q, nflits_d;
    logic [N_W-1:0]           idx_q,    idx_d;
    hdr_t                     hdr_q,    hdr_d;
    logic [SEQ_WIDTH-1:0]     seq_q,    seq_d;
    logic [PKT_ID_WIDTH-1:0]  pid_q,    pid_d;
    logic [PKT_ID_WIDTH-1:0]  pid_cur_q, pid_cur_d;
    error_code_e              err_q,    err_d;

    logic [CAP_W-1:0]         cap_payload;
    int                       n_req;
    logic                     accept;
    logic                     oversize;
    logic                     xfer;
    logic                     last;

    // Only the bytes that can ever be emitted are captured; bytes at or
    // beyond payload_size are zeroed here so every later slice is clean.
    for (genvar b = 0; b < CAP_BYTES; b++) begin : g_cap
        if (b < MAX_PAYLOAD_SIZE) begin : g_live
            assign cap_payload[b*8 +: 8] =
                (SIZE_W'(b) < payload_size) ? payload_data[b*8 +: 8] : 8'h00;
        end else begin : g_pad
            assign cap_payload[b*8 +: 8] = 8'h00;
        end
    end

    // Flit count needed for this request; zero-length payloads still
    // produce one flit.
    always_comb begin
        n_req = (int'(payload_size) * 8 + FLIT_PAYLOAD_WIDTH - 1) / FLIT_PAYLOAD_WIDTH;
        if (n_req < 1) begin
            n_req = 1;
        end
    end

    assign accept   = pkt_valid && (state_q == IDLE);
    assign oversize = (n_req > FLITS_PER_PACKET);
    assign xfer     = (state_q == SEND) && flit_ready;
    assign last     = (idx_q == (nflits_q - N_W'(1)));

    // ------------------------------------------------------------------
    // FSM: next state and handshake / status outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        pkt_ready      = 1'b0;
        flit_valid     = 1'b0;
        error_detected = 1'b0;
        case (state_q)
            IDLE: begin
                pkt_ready = 1'b1;
                if (pkt_valid) begin
                    state_d = oversize ? DROP : SEND;
                end
            end
            SEND: begin
                flit_valid = 1'b1;
                if (flit_ready && last) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                error_detected = 1'b1;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        payload_d = payload_q;
        nflits_d  = nflits_q;
        idx_d     = idx_q;
        hdr_d     = hdr_q;
        seq_d     = seq_q;
        pid_d     = pid_q;
        pid_cur_d = pid_cur_q;
        err_d     = err_q;
        if (accept) begin
            if (oversize) begin
                err_d = ERR_PROTOCOL;
            end else begin
                payload_d    = cap_payload;
                nflits_d     = N_W'(n_req);
                idx_d        = '0;
                hdr_d.src_x  = src_x;
                hdr_d.src_y  = src_y;
                hdr_d.dest_x = dest_x;
                hdr_d.dest_y = dest_y;
                hdr_d.vc_id  = vc_id;
                hdr_d.qos    = qos;
                pid_cur_d    = pid_q;
                pid_d        = pid_q + PKT_ID_WIDTH'(1);
            end
        end else if (xfer) begin
            // Next flit's payload always sits in the low 208 bits.
            payload_d = payload_q >> FLIT_PAYLOAD_WIDTH;
            idx_d     = idx_q + N_W'(1);
            seq_d     = seq_q + SEQ_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            payload_q <= '0;
            nflits_q  <= '0;
            idx_q     <= '0;
            hdr_q     <= '0;
            seq_q     <= '0;
            pid_q     <= '0;
            pid_cur_q <= '0;
            err_q     <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
            nflits_q  <= nflits_d;
            idx_q     <= idx_d;
            hdr_q     <= hdr_d;
            seq_q     <= seq_d;
            pid_q     <= pid_d;
            pid_cur_q <= pid_cur_d;
            err_q     <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Flit assembly: built purely from registers, so it cannot change
    // while a flit is stalled; driven to zero outside SEND.
    // ------------------------------------------------------------------
    always_comb begin
        flit_out = '0;
        if (state_q == SEND) begin
            if (nflits_q == N_W'(1)) begin
                flit_out.flit_type = FLIT_SINGLE;
            end else if (idx_q == '0) begin
                flit_out.flit_type = FLIT_HEAD;
            end else if (last) begin
                flit_out.flit_type = FLIT_TAIL;
            end else begin
                flit_out.flit_type = FLIT_BODY;
            end
            flit_out.src_x     = hdr_q.src_x;
            flit_out.src_y     = hdr_q.src_y;
            flit_out.dest_x    = hdr_q.dest_x;
            flit_out.dest_y    = hdr_q.dest_y;
            flit_out.vc_id     = hdr_q.vc_id;
            flit_out.qos       = hdr_q.qos;
            flit_out.packet_id = pid_cur_q;
            flit_out.seq_num   = seq_q;
            flit_out.payload   = payload_q[FLIT_PAYLOAD_WIDTH-1:0];
        end
    end

    assign error_code = err_q;

`ifdef NEBULA_ASM_STATS_EN
    logic [31:0] st_pkt_q;
    logic [31:0] st_flit_q;
    logic [15:0] st_drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_pkt_q  <= '0;
            st_flit_q <= '0;
            st_drop_q <= '0;
        end else begin
            if (xfer && last && (st_pkt_q != '1)) begin
                st_pkt_q <= st_pkt_q + 32'd1;
            end
            if (xfer && (st_flit_q != '1)) begin
                st_flit_q <= st_flit_q + 32'd1;
            end
            if ((state_q == DROP) && (st_drop_q != '1)) begin
                st_drop_q <= st_drop_q + 16'd1;
            end
        end
    end

    assign stats_pkt_count  = st_pkt_q;
    assign stats_flit_count = st_flit_q;
    assign stats_drop_count = st_drop_q;
`endif

endmodule
`default_nettype wire
